// File: rtl/monitor_prg_pkg.sv
// Shared encodings for the monitor program-memory loader: FSM states,
// Avalon register offsets and CMD/STATUS bit positions.
package monitor_prg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HREQ   = 3'd1,
        ST_SETUP  = 3'd2,
        ST_STROBE = 3'd3,
        ST_HOLD   = 3'd4,
        ST_SAMPLE = 3'd5
    } state_e;

    localparam logic [1:0] REG_ADDR   = 2'd0;
    localparam logic [1:0] REG_DATA   = 2'd1;
    localparam logic [1:0] REG_CMD    = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int CMD_READ    = 0;
    localparam int CMD_AUTOINC = 1;
    localparam int CMD_RELEASE = 2;
    localparam int CMD_CLEAR   = 7;

    localparam int STS_BUSY    = 0;
    localparam int STS_HALTED  = 1;
    localparam int STS_ERR     = 2;
    localparam int STS_OVR     = 3;
    localparam int STS_AUTOINC = 4;

    // The timer counts down to zero inclusive, so an N-cycle phase loads N-1.
    function automatic logic [7:0] cyc_load(input int n);
        return 8'(n - 1);
    endfunction

endpackage

// File: rtl/monitor_cycle_timer.sv
// Loadable 8-bit down counter shared by every phase delay and the ack timeout.
// It stops at zero; 'zero' flags that the current phase has run its course.
module monitor_cycle_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic       zero
);

    logic [7:0] cnt_q, cnt_d;

    // Load takes priority; otherwise count down and park at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == 8'd0);

endmodule

// File: rtl/monitor_prg_loader.sv
// Avalon-MM slave that lets the monitor read and write the target CPU's
// program memory: it halts the target via a req/ack handshake, then runs a
// timed setup/strobe/hold write or a timed sample read, with optional
// address auto-increment.
module monitor_prg_loader
    import monitor_prg_pkg::*;
#(
    parameter int AW         = 8,
    parameter int DW         = 8,
    parameter int SETUP_CYC  = 2,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1,
    parameter int READ_CYC   = 2,
    parameter int ACK_TMO    = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    address,
    input  logic          chipselect,
    input  logic          write_n,
    input  logic [31:0]   writedata,
    output logic [31:0]   readdata,
    output logic          cpu_halt_req,
    input  logic          cpu_halt_ack,
    output logic [AW-1:0] prg_ma,
    output logic [DW-1:0] prg_md_out,
    output logic          prg_we,
    input  logic [DW-1:0] prg_md_in
);

    localparam logic [AW-1:0] MA_ONE = AW'(1);

    state_e        state_q, state_d;
    logic [AW-1:0] ma_q, ma_d;
    logic [DW-1:0] md_q, md_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          autoinc_q, autoinc_d;
    logic          err_q, err_d;
    logic          ovr_q, ovr_d;
    logic          halt_req_q, halt_req_d;
    logic          prg_we_q, prg_we_d;
    logic          is_write_q, is_write_d;

    logic          wr;
    logic          timer_load;
    logic [7:0]    timer_val;
    logic          timer_zero;

    assign wr = chipselect & ~write_n;

    monitor_cycle_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_val (timer_val),
        .zero     (timer_zero)
    );

    // Next-state logic: register writes in IDLE, phase sequencing, overrun capture.
    always_comb begin
        state_d    = state_q;
        ma_d       = ma_q;
        md_d       = md_q;
        rdata_d    = rdata_q;
        autoinc_d  = autoinc_q;
        err_d      = err_q;
        ovr_d      = ovr_q;
        halt_req_d = halt_req_q;
        is_write_d = is_write_q;
        timer_load = 1'b0;
        timer_val  = 8'd0;

        case (state_q)
            ST_IDLE: begin
                if (wr) begin
                    case (address)
                        REG_ADDR: ma_d = writedata[AW-1:0];
                        REG_DATA: begin
                            md_d       = writedata[DW-1:0];
                            is_write_d = 1'b1;
                            halt_req_d = 1'b1;
                            state_d    = ST_HREQ;
                            timer_load = 1'b1;
                            timer_val  = cyc_load(ACK_TMO);
                        end
                        REG_CMD: begin
                            autoinc_d = writedata[CMD_AUTOINC];
                            if (writedata[CMD_CLEAR]) begin
                                err_d = 1'b0;
                                ovr_d = 1'b0;
                            end
                            if (writedata[CMD_READ]) begin
                                is_write_d = 1'b0;
                                halt_req_d = 1'b1;
                                state_d    = ST_HREQ;
                                timer_load = 1'b1;
                                timer_val  = cyc_load(ACK_TMO);
                            end else if (writedata[CMD_RELEASE]) begin
                                halt_req_d = 1'b0;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_HREQ: begin
                if (cpu_halt_ack) begin
                    timer_load = 1'b1;
                    if (is_write_q) begin
                        state_d   = ST_SETUP;
                        timer_val = cyc_load(SETUP_CYC);
                    end else begin
                        state_d   = ST_SAMPLE;
                        timer_val = cyc_load(READ_CYC);
                    end
                end else if (timer_zero) begin
                    err_d      = 1'b1;
                    halt_req_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (timer_zero) begin
                    state_d    = ST_STROBE;
                    timer_load = 1'b1;
                    timer_val  = cyc_load(STROBE_CYC);
                end
            end
            ST_STROBE: begin
                if (timer_zero) begin
                    state_d    = ST_HOLD;
                    timer_load = 1'b1;
                    timer_val  = cyc_load(HOLD_CYC);
                end
            end
            ST_HOLD: begin
                if (timer_zero) begin
                    state_d = ST_IDLE;
                    if (autoinc_q) ma_d = ma_q + MA_ONE;
                end
            end
            ST_SAMPLE: begin
                if (timer_zero) begin
                    rdata_d = prg_md_in;
                    state_d = ST_IDLE;
                    if (autoinc_q) ma_d = ma_q + MA_ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_q != ST_IDLE && wr && address != REG_STATUS) begin
            ovr_d = 1'b1;
        end

        prg_we_d = (state_d == ST_STROBE);
    end

    // State and register file; prg_we is a flop so reset drops it asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ma_q       <= '0;
            md_q       <= '0;
            rdata_q    <= '0;
            autoinc_q  <= 1'b0;
            err_q      <= 1'b0;
            ovr_q      <= 1'b0;
            halt_req_q <= 1'b0;
            prg_we_q   <= 1'b0;
            is_write_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ma_q       <= ma_d;
            md_q       <= md_d;
            rdata_q    <= rdata_d;
            autoinc_q  <= autoinc_d;
            err_q      <= err_d;
            ovr_q      <= ovr_d;
            halt_req_q <= halt_req_d;
            prg_we_q   <= prg_we_d;
            is_write_q <= is_write_d;
        end
    end

    // Zero-wait-state read mux; unused bits stay 0.
    always_comb begin
        readdata = 32'd0;
        case (address)
            REG_ADDR: readdata[AW-1:0] = ma_q;
            REG_DATA: readdata[DW-1:0] = rdata_q;
            REG_STATUS: begin
                readdata[STS_BUSY]    = (state_q != ST_IDLE);
                readdata[STS_HALTED]  = cpu_halt_ack;
                readdata[STS_ERR]     = err_q;
                readdata[STS_OVR]     = ovr_q;
                readdata[STS_AUTOINC] = autoinc_q;
            end
            default: ;
        endcase
    end

    assign cpu_halt_req = halt_req_q;
    assign prg_ma       = ma_q;
    assign prg_md_out   = md_q;
    assign prg_we       = prg_we_q;

endmodule

// File: tb/tb_monitor_prg_loader.sv
// Directed bench for monitor_prg_loader: a register-access vector table plus
// hand-written sequences for strobe timing, ack timeout, overrun and reset.
module tb_monitor_prg_loader;
    import monitor_prg_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        cpu_halt_req;
    logic        cpu_halt_ack;
    logic [7:0]  prg_ma;
    logic [7:0]  prg_md_out;
    logic        prg_we;
    logic [7:0]  prg_md_in;

    logic        ack_en;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  mem [256];
    int          we_cnt = 0;
    logic        we_prev = 1'b0;

    typedef struct {
        bit          is_wr;
        logic [1:0]  addr;
        logic [31:0] wd;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs [28];

    monitor_prg_loader dut (
        .clk          (clk),
        .reset        (reset),
        .address      (address),
        .chipselect   (chipselect),
        .write_n      (write_n),
        .writedata    (writedata),
        .readdata     (readdata),
        .cpu_halt_req (cpu_halt_req),
        .cpu_halt_ack (cpu_halt_ack),
        .prg_ma       (prg_ma),
        .prg_md_out   (prg_md_out),
        .prg_we       (prg_we),
        .prg_md_in    (prg_md_in)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Target model: acknowledges the halt when enabled; memory reads return addr ^ 0x1C.
    assign cpu_halt_ack = ack_en & cpu_halt_req;
    assign prg_md_in    = prg_ma ^ 8'h1C;

    // Program-memory model capturing strobed writes and counting strobe pulses.
    always @(posedge clk) begin
        if (prg_we) mem[prg_ma] <= prg_md_out;
        if (prg_we && !we_prev) we_cnt <= we_cnt + 1;
        we_prev <= prg_we;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    task automatic wait_idle(input string name);
        address = REG_STATUS;
        for (int n = 0; n < 600; n++) begin
            #1;
            if (!readdata[STS_BUSY]) break;
            @(negedge clk);
        end
        checkOutput({name, "_idle"}, {31'd0, readdata[STS_BUSY]}, 32'd0);
    endtask

    task automatic applyStimulus(input vec_t v);
        logic [31:0] rd;
        if (v.is_wr) begin
            bus_write(v.addr, v.wd);
            wait_idle(v.name);
        end else begin
            bus_read(v.addr, rd);
            checkOutput(v.name, rd, v.exp);
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        exp_we   [8];
        logic        exp_busy [8];
        int          cnt;
        int          we_saved;

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        reset      = 1'b1;
        address    = REG_STATUS;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
        ack_en     = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        vecs[0]  = '{1'b0, REG_STATUS, 32'h00, 32'h00, "rst_status"};
        vecs[1]  = '{1'b0, REG_ADDR,   32'h00, 32'h00, "rst_addr"};
        vecs[2]  = '{1'b0, REG_DATA,   32'h00, 32'h00, "rst_data"};
        vecs[3]  = '{1'b1, REG_ADDR,   32'h10, 32'h00, "wr_addr10"};
        vecs[4]  = '{1'b0, REG_ADDR,   32'h00, 32'h10, "addr_rb"};
        vecs[5]  = '{1'b1, REG_DATA,   32'hA5, 32'h00, "wr_a5"};
        vecs[6]  = '{1'b0, REG_STATUS, 32'h00, 32'h02, "halted_after_wr"};
        vecs[7]  = '{1'b1, REG_CMD,    32'h04, 32'h00, "release"};
        vecs[8]  = '{1'b0, REG_STATUS, 32'h00, 32'h00, "released"};
        vecs[9]  = '{1'b1, REG_CMD,    32'h02, 32'h00, "autoinc_set"};
        vecs[10] = '{1'b0, REG_STATUS, 32'h00, 32'h10, "autoinc_on"};
        vecs[11] = '{1'b1, REG_ADDR,   32'hFE, 32'h00, "wr_addrfe"};
        vecs[12] = '{1'b1, REG_DATA,   32'h11, 32'h00, "wr_11"};
        vecs[13] = '{1'b0, REG_ADDR,   32'h00, 32'hFF, "ainc_ff"};
        vecs[14] = '{1'b1, REG_DATA,   32'h22, 32'h00, "wr_22"};
        vecs[15] = '{1'b0, REG_ADDR,   32'h00, 32'h00, "ainc_wrap"};
        vecs[16] = '{1'b1, REG_DATA,   32'h33, 32'h00, "wr_33"};
        vecs[17] = '{1'b0, REG_ADDR,   32'h00, 32'h01, "ainc_01"};
        vecs[18] = '{1'b1, REG_CMD,    32'h00, 32'h00, "autoinc_clr"};
        vecs[19] = '{1'b0, REG_STATUS, 32'h00, 32'h02, "autoinc_off"};
        vecs[20] = '{1'b1, REG_ADDR,   32'h20, 32'h00, "wr_addr20"};
        vecs[21] = '{1'b1, REG_CMD,    32'h01, 32'h00, "rd_start"};
        vecs[22] = '{1'b0, REG_DATA,   32'h00, 32'h3C, "rd_data3c"};
        vecs[23] = '{1'b0, REG_ADDR,   32'h00, 32'h20, "rd_no_ainc"};
        vecs[24] = '{1'b1, REG_ADDR,   32'h33, 32'h00, "wr_addr33"};
        vecs[25] = '{1'b1, REG_CMD,    32'h05, 32'h00, "rd_and_rel"};
        vecs[26] = '{1'b0, REG_DATA,   32'h00, 32'h2F, "rd_data2f"};
        vecs[27] = '{1'b0, REG_STATUS, 32'h00, 32'h02, "rel_ignored"};

        for (int i = 0; i < 28; i++) applyStimulus(vecs[i]);

        checkOutput("mem_10", {24'd0, mem[8'h10]}, 32'hA5);
        checkOutput("mem_fe", {24'd0, mem[8'hFE]}, 32'h11);
        checkOutput("mem_ff", {24'd0, mem[8'hFF]}, 32'h22);
        checkOutput("mem_00", {24'd0, mem[8'h00]}, 32'h33);
        checkOutput("strobe_count", 32'(we_cnt), 32'd4);

        // Write waveform: HREQ 1, SETUP 2, STROBE 2, HOLD 1, then idle.
        exp_we   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        exp_busy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        bus_write(REG_ADDR, 32'h10);
        bus_write(REG_DATA, 32'hA5);
        address = REG_STATUS;
        for (int k = 0; k < 8; k++) begin
            #1;
            checkOutput($sformatf("wave_we_%0d", k), {31'd0, prg_we}, {31'd0, exp_we[k]});
            checkOutput($sformatf("wave_busy_%0d", k), {31'd0, readdata[STS_BUSY]}, {31'd0, exp_busy[k]});
            checkOutput($sformatf("wave_mamd_%0d", k), {16'd0, prg_ma, prg_md_out}, 32'h10A5);
            @(negedge clk);
        end

        // Ack timeout: 255 cycles in HREQ, then err and halt released.
        bus_write(REG_CMD, 32'h04);
        ack_en   = 1'b0;
        we_saved = we_cnt;
        bus_write(REG_DATA, 32'h77);
        address = REG_STATUS;
        cnt = 0;
        for (int n = 0; n < 400; n++) begin
            #1;
            if (!readdata[STS_BUSY]) break;
            cnt++;
            @(negedge clk);
        end
        checkOutput("tmo_cycles", 32'(cnt), 32'd255);
        bus_read(REG_STATUS, rd);
        checkOutput("tmo_status", rd, 32'h04);
        checkOutput("tmo_halt_req", {31'd0, cpu_halt_req}, 32'd0);
        checkOutput("tmo_no_we", 32'(we_cnt), 32'(we_saved));
        ack_en = 1'b1;
        bus_write(REG_CMD, 32'h80);
        bus_read(REG_STATUS, rd);
        checkOutput("err_cleared", rd, 32'h00);

        // Overrun: second DATA write lands while the first is in flight.
        bus_write(REG_ADDR, 32'h40);
        bus_write(REG_DATA, 32'h5A);
        bus_write(REG_DATA, 32'hC3);
        wait_idle("ovr_op");
        bus_read(REG_STATUS, rd);
        checkOutput("ovr_status", rd, 32'h0A);
        checkOutput("ovr_md_kept", {24'd0, prg_md_out}, 32'h5A);
        checkOutput("ovr_mem_40", {24'd0, mem[8'h40]}, 32'h5A);
        bus_write(REG_CMD, 32'h04);
        #1;
        checkOutput("rel_halt_drop", {31'd0, cpu_halt_req}, 32'd0);
        bus_read(REG_STATUS, rd);
        checkOutput("ovr_sticky", rd, 32'h08);
        bus_write(REG_CMD, 32'h80);
        bus_read(REG_STATUS, rd);
        checkOutput("ovr_cleared", rd, 32'h00);

        // Reset asserted mid-strobe clears everything without a clock edge.
        bus_write(REG_ADDR, 32'h55);
        bus_write(REG_DATA, 32'h99);
        for (int n = 0; n < 20; n++) begin
            #1;
            if (prg_we) break;
            @(negedge clk);
        end
        checkOutput("strobe_seen", {31'd0, prg_we}, 32'd1);
        address = REG_STATUS;
        #2;
        reset = 1'b1;
        #1;
        checkOutput("rst_we", {31'd0, prg_we}, 32'd0);
        checkOutput("rst_halt_req", {31'd0, cpu_halt_req}, 32'd0);
        checkOutput("rst_busy_status", readdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        bus_read(REG_ADDR, rd);
        checkOutput("rst2_addr", rd, 32'd0);
        bus_read(REG_DATA, rd);
        checkOutput("rst2_data", rd, 32'd0);
        bus_read(REG_STATUS, rd);
        checkOutput("rst2_status", rd, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
